// File: rtl/mux_scan_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the mux scan sequencer slice.
//   - scan_state_t : sequencer FSM states (IDLE, SETTLE, SAMPLE, DONE)
//   - MUX_SCAN_NUM_CH / MUX_SCAN_SETTLE : default channel count and settle time
// No ports (package).
// ---------------------------------------------------------------------------
package mux_scan_pkg;

    localparam int MUX_SCAN_NUM_CH = 8;
    localparam int MUX_SCAN_SETTLE = 1;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } scan_state_t;

endpackage

// File: rtl/scan_settle_timer.sv
// ---------------------------------------------------------------------------
// scan_settle_timer
// Loadable down-counter used to hold the mux select for a fixed number of
// cycles before a sample is taken. Once loaded it counts down by one per
// cycle and then rests at zero until it is loaded again.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset (count -> 0)
//   load     in   load load_val this cycle (wins over counting)
//   load_val in   W  value to load
//   zero     out  count is zero
// ---------------------------------------------------------------------------
module scan_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Counter register: a load always takes priority so the sequencer can
    // restart the wait on the same edge that ends the previous one; otherwise
    // count down and park at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// mux_scan_sequencer
// Steps an external NUM_CH:1 mux through every channel, waits SETTLE cycles
// on each select value, samples the mux output and assembles a NUM_CH-bit
// snapshot that is offered to a consumer over a valid/ready handshake.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   single-cycle scan request (ignored while busy)
//   cont_en    in   continuous mode, sampled at each handshake
//   mux_out    in   output of the scanned mux
//   sel        out  SEL_W  mux select
//   busy       out  scan in progress / word waiting
//   data       out  NUM_CH snapshot, bit i sampled with sel=i
//   data_valid out  snapshot available
//   changed    out  NUM_CH (MUX_SCAN_CHANGE_DET_EN only) data ^ previous word
//   any_change out  (MUX_SCAN_CHANGE_DET_EN only) |changed
//   data_ready in   consumer accepts when data_valid && data_ready
// Optional feature macro: MUX_SCAN_CHANGE_DET_EN
// ---------------------------------------------------------------------------
module mux_scan_sequencer #(
    parameter int  NUM_CH = mux_scan_pkg::MUX_SCAN_NUM_CH,
    parameter int  SETTLE = mux_scan_pkg::MUX_SCAN_SETTLE,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont_en,
    input  logic              mux_out,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [NUM_CH-1:0] data,
    output logic              data_valid,
`ifdef MUX_SCAN_CHANGE_DET_EN
    output logic [NUM_CH-1:0] changed,
    output logic              any_change,
`endif
    input  logic              data_ready
);

    import mux_scan_pkg::*;

    // The timer only ever holds SETTLE-1, so it never needs more bits than that.
    localparam int               CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    scan_state_t       state;
    logic [NUM_CH-1:0] acc;
    logic [NUM_CH-1:0] acc_next;
    logic              handshake;
    logic              timer_load;
    logic              timer_zero;
    logic              word_done;

    assign handshake = data_valid && data_ready;
    assign word_done = (state == SAMPLE) && (sel == LAST_SEL);

    // The accumulator with the current sample merged in. Using it for both
    // acc and data lets the final channel land in the delivered word on the
    // same edge it is sampled.
    always_comb begin
        acc_next      = acc;
        acc_next[sel] = mux_out;
    end

    // A fresh settle wait starts whenever the FSM enters SETTLE: from an
    // accepted start, after a non-final sample, or on a continuous handshake.
    always_comb begin
        timer_load = 1'b0;
        case (state)
            IDLE:    timer_load = start;
            SAMPLE:  timer_load = (sel != LAST_SEL);
            DONE:    timer_load = handshake && cont_en;
            default: timer_load = 1'b0;
        endcase
    end

    scan_settle_timer #(
        .W(CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .zero     (timer_zero)
    );

    // Main sequencer. All outputs are registered here so sel never glitches
    // into the mux and data/data_valid only move together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            acc        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sel <= '0;
                    if (start) begin
                        state <= mux_scan_pkg::SETTLE;
                        busy  <= 1'b1;
                    end
                end
                mux_scan_pkg::SETTLE: begin
                    if (timer_zero) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    acc <= acc_next;
                    if (sel == LAST_SEL) begin
                        state      <= DONE;
                        data       <= acc_next;
                        data_valid <= 1'b1;
                    end else begin
                        sel   <= sel + 1'b1;
                        state <= mux_scan_pkg::SETTLE;
                    end
                end
                DONE: begin
                    if (handshake) begin
                        data_valid <= 1'b0;
                        sel        <= '0;
                        if (cont_en) begin
                            state <= mux_scan_pkg::SETTLE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MUX_SCAN_CHANGE_DET_EN
    logic [NUM_CH-1:0] prev_word;

    // Change detection: the difference is captured alongside data, and the
    // reference word only advances once the consumer has taken a snapshot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_word <= '0;
            changed   <= '0;
        end else begin
            if (word_done) begin
                changed <= acc_next ^ prev_word;
            end
            if (handshake) begin
                prev_word <= data;
            end
        end
    end

    assign any_change = |changed;
`else
    logic unused_word_done;
    assign unused_word_done = word_done;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_sequencer
// Bench for mux_scan_sequencer. Two instances: dut0 at the default settle
// time (1) and dut1 with SETTLE=3. Each drives a behavioural 8:1 mux built
// from its own input vector x. Honors MUX_SCAN_CHANGE_DET_EN.
// ---------------------------------------------------------------------------
module tb_mux_scan_sequencer;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n_a [2];
    logic       start_a [2];
    logic       cont_a  [2];
    logic       ready_a [2];
    logic       mux_a   [2];
    logic       valid_a [2];
    logic       busy_a  [2];
    logic [7:0] x_a     [2];
    logic [7:0] data_a  [2];
    logic [2:0] sel_a   [2];
`ifdef MUX_SCAN_CHANGE_DET_EN
    logic [7:0] chg_a   [2];
    logic       anyc_a  [2];
`endif

    int checks   = 0;
    int failures = 0;
    bit armed [2];

    // Reference model state: scan progress is tracked as an edge count since
    // the scan began, channel i being sampled after (i+1)*(SETTLE+1) edges.
    bit         m_active [2];
    bit         m_valid  [2];
    bit         m_busy   [2];
    int         m_k      [2];
    logic [2:0] m_sel    [2];
    logic [7:0] m_word   [2];
    logic [7:0] m_data   [2];
    logic [7:0] m_prev   [2];
    logic [7:0] m_chg    [2];

    always #5 clk = ~clk;

    // Behavioural stand-ins for the 8:1 mux feeding each sequencer.
    assign mux_a[0] = x_a[0][sel_a[0]];
    assign mux_a[1] = x_a[1][sel_a[1]];

    mux_scan_sequencer dut0 (
        .clk        (clk),
        .rst_n      (rst_n_a[0]),
        .start      (start_a[0]),
        .cont_en    (cont_a[0]),
        .mux_out    (mux_a[0]),
        .sel        (sel_a[0]),
        .busy       (busy_a[0]),
        .data       (data_a[0]),
        .data_valid (valid_a[0]),
`ifdef MUX_SCAN_CHANGE_DET_EN
        .changed    (chg_a[0]),
        .any_change (anyc_a[0]),
`endif
        .data_ready (ready_a[0])
    );

    mux_scan_sequencer #(
        .NUM_CH (8),
        .SETTLE (3)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n_a[1]),
        .start      (start_a[1]),
        .cont_en    (cont_a[1]),
        .mux_out    (mux_a[1]),
        .sel        (sel_a[1]),
        .busy       (busy_a[1]),
        .data       (data_a[1]),
        .data_valid (valid_a[1]),
`ifdef MUX_SCAN_CHANGE_DET_EN
        .changed    (chg_a[1]),
        .any_change (anyc_a[1]),
`endif
        .data_ready (ready_a[1])
    );

    function automatic int settle_of(input int inst);
        return (inst == 0) ? 1 : 3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int inst, input logic [7:0] xv, input logic c, input logic r);
        x_a[inst]     = xv;
        cont_a[inst]  = c;
        ready_a[inst] = r;
        start_a[inst] = 1'b1;
        @(negedge clk);
        start_a[inst] = 1'b0;
    endtask

    // Cycle 1 is the negedge right after the edge that accepted the request.
    task automatic waitValid(input int inst, input int budget, output int cyc);
        cyc = 1;
        while (valid_a[inst] !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (valid_a[inst] !== 1'b1) checkOutput($sformatf("dut%0d valid timeout", inst), 0, 1);
    endtask

    // Reference model, advanced on every rising edge from the inputs the
    // bench is holding (inputs only change on falling edges).
    initial begin
        for (int i = 0; i < 2; i++) begin
            armed[i] = 1'b0; m_active[i] = 1'b0; m_valid[i] = 1'b0; m_busy[i] = 1'b0;
            m_k[i] = 0; m_sel[i] = '0; m_word[i] = '0; m_data[i] = '0; m_prev[i] = '0; m_chg[i] = '0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                int s;
                int ch;
                s = settle_of(i);
                if (rst_n_a[i] === 1'b0) begin
                    armed[i] = 1'b1; m_active[i] = 1'b0; m_valid[i] = 1'b0; m_busy[i] = 1'b0;
                    m_k[i] = 0; m_sel[i] = '0; m_word[i] = '0; m_data[i] = '0; m_prev[i] = '0; m_chg[i] = '0;
                end else if (m_valid[i]) begin
                    if (ready_a[i]) begin
                        m_prev[i]  = m_data[i];
                        m_valid[i] = 1'b0;
                        m_sel[i]   = '0;
                        m_k[i]     = 0;
                        if (!cont_a[i]) begin
                            m_active[i] = 1'b0;
                            m_busy[i]   = 1'b0;
                        end
                    end
                end else if (m_active[i]) begin
                    m_k[i]++;
                    if (m_k[i] % (s + 1) == 0) begin
                        ch = m_k[i] / (s + 1) - 1;
                        m_word[i][ch] = x_a[i][ch];
                        if (ch == N - 1) begin
                            m_valid[i] = 1'b1;
                            m_data[i]  = m_word[i];
                            m_chg[i]   = m_word[i] ^ m_prev[i];
                        end else begin
                            m_sel[i] = 3'(ch + 1);
                        end
                    end
                end else if (start_a[i]) begin
                    m_active[i] = 1'b1;
                    m_busy[i]   = 1'b1;
                    m_k[i]      = 0;
                    m_sel[i]    = '0;
                end
            end
        end
    end

    // Every falling edge, once an instance has seen reset, its outputs must
    // match the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (armed[i]) begin
                    checkOutput($sformatf("dut%0d sel", i), 32'(sel_a[i]), 32'(m_sel[i]));
                    checkOutput($sformatf("dut%0d busy", i), 32'(busy_a[i]), 32'(m_busy[i]));
                    checkOutput($sformatf("dut%0d data_valid", i), 32'(valid_a[i]), 32'(m_valid[i]));
                    checkOutput($sformatf("dut%0d data", i), 32'(data_a[i]), 32'(m_data[i]));
`ifdef MUX_SCAN_CHANGE_DET_EN
                    checkOutput($sformatf("dut%0d changed", i), 32'(chg_a[i]), 32'(m_chg[i]));
                    checkOutput($sformatf("dut%0d any_change", i), 32'(anyc_a[i]), 32'(|m_chg[i]));
`endif
                end
            end
        end
    end

    // Watchdog so a stuck run still reports and stops.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        int  cyc;
        bit  seen;
        for (int i = 0; i < 2; i++) begin
            rst_n_a[i] = 1'b0; start_a[i] = 1'b0; cont_a[i] = 1'b0;
            ready_a[i] = 1'b1; x_a[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        checkOutput("reset sel", 32'(sel_a[0]), 0);
        checkOutput("reset data", 32'(data_a[0]), 0);
        checkOutput("reset data_valid", 32'(valid_a[0]), 0);
        checkOutput("reset busy", 32'(busy_a[0]), 0);
        rst_n_a[0] = 1'b1;
        rst_n_a[1] = 1'b1;
        @(negedge clk);

        // Basic scan: x0..x7 = 1,1,0,1,1,1,0,1 gives 8'hBB.
        $display("[TB] basic scan");
        applyStimulus(0, 8'hBB, 1'b0, 1'b1);
        waitValid(0, 100, cyc);
        checkOutput("basic latency", 32'(cyc), 17);
        checkOutput("basic data", 32'(data_a[0]), 32'h BB);
        @(negedge clk);
        checkOutput("basic busy drop", 32'(busy_a[0]), 0);
        checkOutput("basic sel idle", 32'(sel_a[0]), 0);

        // Backpressure: consumer stalls 5 cycles, a stray start is ignored.
        $display("[TB] backpressure");
        applyStimulus(0, 8'hBB, 1'b0, 1'b0);
        waitValid(0, 100, cyc);
        for (int j = 0; j < 5; j++) begin
            checkOutput("stall data", 32'(data_a[0]), 32'h BB);
            checkOutput("stall sel", 32'(sel_a[0]), 7);
            checkOutput("stall valid", 32'(valid_a[0]), 1);
            start_a[0] = (j == 1);
            if (j == 4) ready_a[0] = 1'b1;
            @(negedge clk);
        end
        checkOutput("stall release valid", 32'(valid_a[0]), 0);
        checkOutput("stall release busy", 32'(busy_a[0]), 0);
        repeat (2) @(negedge clk);
        checkOutput("stall no rescan", 32'(busy_a[0]), 0);

        // Continuous mode: second word starts right after the handshake.
        $display("[TB] continuous mode");
        applyStimulus(0, 8'hBB, 1'b1, 1'b1);
        waitValid(0, 100, cyc);
        checkOutput("cont first data", 32'(data_a[0]), 32'h BB);
        @(negedge clk);
        checkOutput("cont sel restart", 32'(sel_a[0]), 0);
        checkOutput("cont busy held", 32'(busy_a[0]), 1);
        checkOutput("cont valid dropped", 32'(valid_a[0]), 0);
        x_a[0]    = 8'h0F;
        cont_a[0] = 1'b0;
        waitValid(0, 100, cyc);
        checkOutput("cont second latency", 32'(cyc), 17);
        checkOutput("cont second data", 32'(data_a[0]), 32'h0F);
        @(negedge clk);
        checkOutput("cont busy drop", 32'(busy_a[0]), 0);

        // Ignored start mid-scan, then reset while sel=4.
        $display("[TB] ignored start and mid-scan reset");
        applyStimulus(0, 8'hBB, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        cyc = 0;
        while (sel_a[0] !== 3'd4 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("reach sel 4", 32'(sel_a[0]), 4);
        rst_n_a[0] = 1'b0;
        @(negedge clk);
        checkOutput("midreset sel", 32'(sel_a[0]), 0);
        checkOutput("midreset data", 32'(data_a[0]), 0);
        checkOutput("midreset valid", 32'(valid_a[0]), 0);
        checkOutput("midreset busy", 32'(busy_a[0]), 0);
        rst_n_a[0] = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (valid_a[0] === 1'b1) seen = 1'b1;
        end
        checkOutput("no valid after reset", 32'(seen), 0);

        // Change detection sequence: BB, B3, B3.
        $display("[TB] change detection sequence");
        applyStimulus(0, 8'hBB, 1'b0, 1'b1);
        waitValid(0, 100, cyc);
        checkOutput("chg word1 data", 32'(data_a[0]), 32'h BB);
`ifdef MUX_SCAN_CHANGE_DET_EN
        checkOutput("chg word1 changed", 32'(chg_a[0]), 32'h BB);
        checkOutput("chg word1 any", 32'(anyc_a[0]), 1);
`endif
        @(negedge clk);
        applyStimulus(0, 8'hB3, 1'b0, 1'b1);
        waitValid(0, 100, cyc);
        checkOutput("chg word2 data", 32'(data_a[0]), 32'h B3);
`ifdef MUX_SCAN_CHANGE_DET_EN
        checkOutput("chg word2 changed", 32'(chg_a[0]), 32'h08);
        checkOutput("chg word2 any", 32'(anyc_a[0]), 1);
`endif
        @(negedge clk);
        applyStimulus(0, 8'hB3, 1'b0, 1'b1);
        waitValid(0, 100, cyc);
        checkOutput("chg word3 data", 32'(data_a[0]), 32'h B3);
`ifdef MUX_SCAN_CHANGE_DET_EN
        checkOutput("chg word3 changed", 32'(chg_a[0]), 0);
        checkOutput("chg word3 any", 32'(anyc_a[0]), 0);
`endif
        @(negedge clk);

        // SETTLE=3 instance: four cycles per channel.
        $display("[TB] settle 3 instance");
        applyStimulus(1, 8'hBB, 1'b0, 1'b1);
        waitValid(1, 200, cyc);
        checkOutput("settle3 latency", 32'(cyc), 33);
        checkOutput("settle3 data", 32'(data_a[1]), 32'h BB);
        @(negedge clk);
        checkOutput("settle3 busy drop", 32'(busy_a[1]), 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
